toggle_window_monitor: RTL and testbench

- Sequential activity monitor placed directly downstream of the standard-cell netlist stage (INV/AND cell instances). It samples a bus of cell output nets every clock and counts bit transitions over fixed windows.
- Each completed window's count is delivered over a valid/ready handshake to the power/thermal estimation logic.
- Per-window switching activity is the input the thermal model consumes.

---
 rtl/toggle_window_monitor_if.sv | 27 ++
 rtl/toggle_window_monitor.sv | 130 +++++++++++++
 tb/tb_toggle_window_monitor.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_window_monitor_if.sv
// Result channel of the toggle window monitor: per-window toggle count
// delivered on a valid/ready handshake, plus saturation and sticky drop flags.
interface toggle_window_monitor_if #(
    parameter int CNT_W = 16
);
    logic             VALID;
    logic             READY;
    logic [CNT_W-1:0] TOG_CNT;
    logic             OVF;
    logic             DROP;

    modport master (
        output VALID,
        output TOG_CNT,
        output OVF,
        output DROP,
        input  READY
    );

    modport slave (
        input  VALID,
        input  TOG_CNT,
        input  OVF,
        input  DROP,
        output READY
    );
endinterface

// File: rtl/toggle_window_monitor.sv
// Counts bit transitions on a bus of cell output nets over fixed windows of
// WIN_LEN cycles and hands each window's saturating count to the consumer.
module toggle_window_monitor #(
    parameter int WIDTH   = 23,
    parameter int CNT_W   = 16,
    parameter int WIN_LEN = 256
) (
    input  logic                    CK,
    input  logic                    RN,
    input  logic                    EN,
    input  logic [WIDTH-1:0]        A,
    toggle_window_monitor_if.master res
);
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam int WC_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    typedef enum logic {
        ST_IDLE,
        ST_COUNT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_q;
    logic [CNT_W-1:0] r_acc;
    logic             r_ovf_acc;
    logic [WC_W-1:0]  r_win_cnt;
    logic             r_valid;
    logic [CNT_W-1:0] r_tog_cnt;
    logic             r_ovf;
    logic             r_drop;

    logic [WIDTH-1:0] w_diff;
    logic [PC_W-1:0]  w_pc;
    logic [SUM_W-1:0] w_sum_raw;
    logic             w_sat;
    logic [CNT_W-1:0] w_sum;
    logic             w_ovf;
    logic             w_win_last;
    logic             w_win_end;
    logic             w_xfer;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default before any branch or loop, so no latch can be inferred.
    always_comb begin
        w_diff = A ^ r_a_q;
        w_pc   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pc = w_pc + PC_W'(w_diff[i]);
        end
    end

    // Widened add so the clip test sees the true sum before saturation.
    assign w_sum_raw  = SUM_W'(r_acc) + SUM_W'(w_pc);
    assign w_sat      = (w_sum_raw > SUM_W'(MAX_CNT));
    assign w_sum      = w_sat ? MAX_CNT : w_sum_raw[CNT_W-1:0];
    assign w_ovf      = r_ovf_acc | w_sat;
    assign w_win_last = (r_win_cnt == WC_W'(WIN_LEN - 1));
    assign w_win_end  = (r_state == ST_COUNT) && EN && w_win_last;
    assign w_xfer     = r_valid && res.READY;

    // NOTE: every register here, including the sample register r_a_q, is
    // reset asynchronously and updated with non-blocking '<=' only.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state   <= ST_IDLE;
            r_a_q     <= '0;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_win_cnt <= '0;
            r_valid   <= 1'b0;
            r_tog_cnt <= '0;
            r_ovf     <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (EN) begin
                        r_a_q     <= A;
                        r_acc     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_win_cnt <= '0;
                        r_state   <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!EN) begin
                        r_acc     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_win_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_a_q <= A;
                        if (w_win_last) begin
                            r_acc     <= '0;
                            r_ovf_acc <= 1'b0;
                            r_win_cnt <= '0;
                        end else begin
                            r_acc     <= w_sum;
                            r_ovf_acc <= w_ovf;
                            r_win_cnt <= r_win_cnt + WC_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A finished window either lands in the result register or is lost.
            if (w_win_end && (!r_valid || res.READY)) begin
                r_tog_cnt <= w_sum;
                r_ovf     <= w_ovf;
                r_valid   <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            if (w_win_end && r_valid && !res.READY) begin
                r_drop <= 1'b1;
            end else if (w_xfer) begin
                r_drop <= 1'b0;
            end
        end
    end

    assign res.VALID   = r_valid;
    assign res.TOG_CNT = r_tog_cnt;
    assign res.OVF     = r_ovf;
    assign res.DROP    = r_drop;
endmodule

// File: tb/tb_toggle_window_monitor.sv
// Bench for toggle_window_monitor: table vectors, hand-written corner
// sequences and a randomized run against a window-level reference model.
module tb_toggle_window_monitor;
    localparam int WA = 4;
    localparam int CA = 8;
    localparam int LA = 4;
    localparam int CB = 4;
    localparam int LB = 8;

    logic          ck;
    logic          rn;
    logic          en_a;
    logic [WA-1:0] a_a;
    logic          en_b;
    logic [WA-1:0] a_b;

    int total = 0;
    int bad   = 0;

    toggle_window_monitor_if #(.CNT_W(CA)) if_a ();
    toggle_window_monitor_if #(.CNT_W(CB)) if_b ();

    toggle_window_monitor #(.WIDTH(WA), .CNT_W(CA), .WIN_LEN(LA)) dut_a (
        .CK(ck), .RN(rn), .EN(en_a), .A(a_a), .res(if_a)
    );

    toggle_window_monitor #(.WIDTH(WA), .CNT_W(CB), .WIN_LEN(LB)) dut_b (
        .CK(ck), .RN(rn), .EN(en_b), .A(a_b), .res(if_b)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Reference model for dut_a: keeps the raw samples of the open window and
    // scores a window only once all WIN_LEN+1 samples are present.
    bit            m_counting;
    logic [WA-1:0] m_win[$];
    bit            m_valid;
    int            m_tog;
    bit            m_ovf;
    bit            m_drop;

    task automatic model_reset();
        m_counting = 0;
        m_win.delete();
        m_valid = 0;
        m_tog   = 0;
        m_ovf   = 0;
        m_drop  = 0;
    endtask

    task automatic model_edge(input bit en, input logic [WA-1:0] a, input bit ready);
        bit done = 0;
        int raw  = 0;
        bit xfer = m_valid && ready;
        if (!en) begin
            m_counting = 0;
            m_win.delete();
        end else if (!m_counting) begin
            m_counting = 1;
            m_win.delete();
            m_win.push_back(a);
        end else begin
            m_win.push_back(a);
            if (m_win.size() == LA + 1) begin
                for (int i = 0; i < LA; i++) raw += $countones(m_win[i] ^ m_win[i+1]);
                done = 1;
                m_win.delete();
                m_win.push_back(a);
            end
        end
        if (done && (!m_valid || ready)) begin
            m_tog   = (raw > 2**CA - 1) ? 2**CA - 1 : raw;
            m_ovf   = (raw > 2**CA - 1);
            m_valid = 1;
            if (xfer) m_drop = 0;
        end else if (done) begin
            m_drop = 1;
        end else if (xfer) begin
            m_valid = 0;
            m_drop  = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string tag, input bit ev, input int et, input bit eo, input bit ed);
        check({tag, " valid"}, int'(if_a.VALID), int'(ev));
        check({tag, " tog"},   int'(if_a.TOG_CNT), et);
        check({tag, " ovf"},   int'(if_a.OVF), int'(eo));
        check({tag, " drop"},  int'(if_a.DROP), int'(ed));
    endtask

    task automatic chk_b(input string tag, input bit ev, input int et, input bit eo, input bit ed);
        check({tag, " valid"}, int'(if_b.VALID), int'(ev));
        check({tag, " tog"},   int'(if_b.TOG_CNT), et);
        check({tag, " ovf"},   int'(if_b.OVF), int'(eo));
        check({tag, " drop"},  int'(if_b.DROP), int'(ed));
    endtask

    // Inputs change on the falling edge; outputs are read on the next one.
    task automatic step_a(input bit en, input logic [WA-1:0] a, input bit ready);
        en_a = en;
        a_a = a;
        if_a.READY = ready;
        @(posedge ck);
        @(negedge ck);
        model_edge(en, a, ready);
    endtask

    task automatic step_b(input bit en, input logic [WA-1:0] a, input bit ready);
        en_b = en;
        a_b = a;
        if_b.READY = ready;
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic do_reset(input string tag);
        #2 rn = 1'b0;
        #1;
        chk_a({tag, " rst_a"}, 0, 0, 0, 0);
        chk_b({tag, " rst_b"}, 0, 0, 0, 0);
        en_a = 0;
        en_b = 0;
        model_reset();
        @(negedge ck);
        rn = 1'b1;
    endtask

    typedef struct {
        bit            en;
        logic [WA-1:0] a;
        bit            ready;
        bit            ev;
        int            et;
        bit            eo;
        bit            ed;
    } vec_t;

    vec_t tbl[11];

    initial begin
        rn = 1'b0;
        en_a = 0; a_a = '0; if_a.READY = 0;
        en_b = 0; a_b = '0; if_b.READY = 0;
        model_reset();
        #2;
        chk_a("init_a", 0, 0, 0, 0);
        chk_b("init_b", 0, 0, 0, 0);
        @(negedge ck);
        rn = 1'b1;

        // Basic window: alternating 0/F gives 4 toggles per cycle, 16 per window.
        tbl[0]  = '{1, 4'h0, 1, 0,  0, 0, 0};
        tbl[1]  = '{1, 4'hF, 1, 0,  0, 0, 0};
        tbl[2]  = '{1, 4'h0, 1, 0,  0, 0, 0};
        tbl[3]  = '{1, 4'hF, 1, 0,  0, 0, 0};
        tbl[4]  = '{1, 4'h0, 1, 1, 16, 0, 0};
        tbl[5]  = '{1, 4'hF, 1, 0, 16, 0, 0};
        tbl[6]  = '{1, 4'h0, 1, 0, 16, 0, 0};
        tbl[7]  = '{1, 4'hF, 1, 0, 16, 0, 0};
        tbl[8]  = '{1, 4'h0, 1, 1, 16, 0, 0};
        tbl[9]  = '{0, 4'h0, 0, 1, 16, 0, 0};
        tbl[10] = '{0, 4'h0, 1, 0, 16, 0, 0};
        for (int i = 0; i < 11; i++) begin
            step_a(tbl[i].en, tbl[i].a, tbl[i].ready);
            chk_a($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].et, tbl[i].eo, tbl[i].ed);
        end

        // Reset mid-window while a result is pending.
        step_a(1, 4'h0, 0);
        for (int i = 1; i <= 4; i++) step_a(1, (i % 2) ? 4'hF : 4'h0, 0);
        chk_a("pre_rst", 1, 16, 0, 0);
        step_a(1, 4'hF, 0);
        do_reset("midwin");

        // No result can appear while EN stays low.
        for (int i = 0; i < 20; i++) begin
            step_a(0, 4'($urandom), 1'($urandom));
            check("en_low valid", int'(if_a.VALID), 0);
        end

        // Backpressure: one toggle per cycle, consumer stalled for two windows.
        do_reset("bp");
        step_a(1, 4'h0, 0);
        for (int i = 1; i <= 3; i++) begin
            step_a(1, (i % 2) ? 4'h1 : 4'h0, 0);
            check("bp_w1 valid", int'(if_a.VALID), 0);
        end
        step_a(1, 4'h0, 0);
        chk_a("bp_first", 1, 4, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step_a(1, (i % 2) ? 4'h1 : 4'h0, 0);
            chk_a("bp_hold", 1, 4, 0, 0);
        end
        step_a(1, 4'h0, 0);
        chk_a("bp_drop", 1, 4, 0, 1);
        step_a(1, 4'h1, 1);
        chk_a("bp_xfer", 0, 4, 0, 0);

        // Window end coinciding with a transfer: new count replaces old, no drop.
        do_reset("sim");
        step_a(1, 4'h0, 0);
        for (int i = 1; i <= 4; i++) step_a(1, (i % 2) ? 4'h1 : 4'h0, 0);
        chk_a("sim_first", 1, 4, 0, 0);
        for (int i = 1; i <= 3; i++) step_a(1, (i % 2) ? 4'h3 : 4'h0, 0);
        step_a(1, 4'h0, 1);
        chk_a("sim_end", 1, 8, 0, 0);
        step_a(1, 4'h3, 1);
        chk_a("sim_after", 0, 8, 0, 0);

        // Abort after two cycles, then a fresh window counts only new toggles.
        do_reset("abort");
        step_a(1, 4'h0, 1);
        step_a(1, 4'hF, 1);
        step_a(1, 4'h0, 1);
        step_a(0, 4'hF, 1);
        check("abort valid", int'(if_a.VALID), 0);
        step_a(1, 4'hF, 1);
        for (int i = 1; i <= 3; i++) begin
            step_a(1, (i % 2) ? 4'hE : 4'hF, 1);
            check("abort_w valid", int'(if_a.VALID), 0);
        end
        step_a(1, 4'hF, 1);
        chk_a("abort_res", 1, 4, 0, 0);

        // Saturation on the narrow-count instance: 32 toggles clip to 15.
        do_reset("sat");
        step_b(1, 4'h0, 1);
        for (int i = 1; i <= 7; i++) begin
            step_b(1, (i % 2) ? 4'hF : 4'h0, 1);
            check("sat_w valid", int'(if_b.VALID), 0);
        end
        step_b(1, 4'h0, 1);
        chk_b("sat_res", 1, 15, 1, 0);
        step_b(1, 4'h0, 1);
        chk_b("sat_xfer", 0, 15, 1, 0);
        for (int i = 2; i <= 7; i++) step_b(1, 4'h0, 1);
        step_b(1, 4'h0, 1);
        chk_b("quiet_res", 1, 0, 0, 0);
        step_b(0, 4'h0, 1);

        // Randomized traffic against the reference model.
        do_reset("rnd");
        for (int i = 0; i < 900; i++) begin
            if (i % 300 == 299) begin
                do_reset("rnd_mid");
            end else begin
                step_a($urandom_range(0, 24) != 0, 4'($urandom),
                       (i % 100 < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
                chk_a("rnd", m_valid, m_tog, m_ovf, m_drop);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
